// File: rtl/siso_pkg.sv
// Shared datapath constants for the serial shift register.
package siso_pkg;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/siso.sv
// Bidirectional serial-in shift register with parallel view of contents.
module siso
    import siso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drt,
    input  logic             lft,
    input  logic             rgt,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (drt == DIR_LEFT) begin
            q <= {q[WIDTH-2:0], lft};
        end else begin
            q <= {rgt, q[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_siso.sv
// Directed self-checking bench for siso at WIDTH=4.
module tb_siso;

    logic       clk;
    logic       rst;
    logic       drt;
    logic       lft;
    logic       rgt;
    logic [3:0] q;

    int tests;
    int fails;

    siso #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .drt(drt),
        .lft(lft),
        .rgt(rgt),
        .q  (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic d,
                        input logic l, input logic g);
        @(negedge clk);
        rst = r;
        drt = d;
        lft = l;
        rgt = g;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        tests++;
        assert (q === exp) else begin
            fails++;
            $error("FAIL %s: q=%b expected=%b", tag, q, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic exp);
        tests++;
        assert (q[3] === exp) else begin
            fails++;
            $error("FAIL %s: q[3]=%b expected=%b", tag, q[3], exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        drt = 1'b1;
        lft = 1'b0;
        rgt = 1'b0;

        // reset held for two edges
        step(1, 1, 0, 0); chk("reset_e1", 4'b0000);
        step(1, 1, 0, 0); chk("reset_e2", 4'b0000);

        // left fill
        step(0, 1, 1, 0); chk("left_1", 4'b0001);
        step(0, 1, 0, 0); chk("left_2", 4'b0010);
        step(0, 1, 1, 0); chk("left_3", 4'b0101);
        step(0, 1, 0, 0); chk("left_4", 4'b1010);

        // right shifts from 1010
        step(0, 0, 0, 1); chk("right_1", 4'b1101);
        step(0, 0, 0, 0); chk("right_2", 4'b0110);
        step(0, 0, 0, 1); chk("right_3", 4'b1011);
        step(0, 0, 0, 0); chk("right_4", 4'b0101);

        // inactive serial input ignored
        step(0, 1, 0, 1); chk("iso_left", 4'b1010);
        step(0, 0, 1, 0); chk("iso_right", 4'b0101);

        // serial latency from cleared register
        step(1, 1, 0, 0); chk("lat_reset", 4'b0000);
        step(0, 1, 1, 0); chk_bit("lat_e1", 1'b0);
        step(0, 1, 0, 1); chk_bit("lat_e2", 1'b0);
        step(0, 1, 0, 0); chk_bit("lat_e3", 1'b0);
        step(0, 1, 0, 1); chk_bit("lat_e4", 1'b1);
        chk("lat_e4_full", 4'b1000);
        step(0, 1, 0, 0); chk("lat_e5", 4'b0000);

        // build 1011, then reset mid-stream
        step(0, 1, 1, 0); chk("mid_1", 4'b0001);
        step(0, 1, 0, 0); chk("mid_2", 4'b0010);
        step(0, 1, 1, 0); chk("mid_3", 4'b0101);
        step(0, 1, 1, 0); chk("mid_4", 4'b1011);
        step(1, 1, 1, 1); chk("mid_rst", 4'b0000);
        step(0, 0, 0, 1); chk("mid_resume", 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
